// File: rtl/operand_fetch.sv
// Two-stage operand fetch: F waits on the one-cycle register-file read, O presents
// resolved operands; write-backs are forwarded at every point an operand can go stale.
module operand_fetch #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 32,
   localparam int AW        = $clog2(REG_NUM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [AW-1:0]         req_rs1,
   input  logic [AW-1:0]         req_rs2,
   input  logic [AW-1:0]         req_rd,
   input  logic                  wb_valid,
   input  logic [AW-1:0]         wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic [AW-1:0]         rs1_addr,
   output logic [AW-1:0]         rs2_addr,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   output logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_wren,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [DATA_WIDTH-1:0] op_a,
   output logic [DATA_WIDTH-1:0] op_b,
   output logic [AW-1:0]         op_rd
);

   // Handshakes: a transfer happens on a cycle where valid && ready are both high;
   // a source holds valid and its payload stable until that cycle.

   logic                  f_valid_q, f_valid_d;
   logic                  f_fresh_q, f_fresh_d;
   logic [AW-1:0]         f_rs1_q, f_rs1_d;
   logic [AW-1:0]         f_rs2_q, f_rs2_d;
   logic [AW-1:0]         f_rd_q, f_rd_d;
   logic                  f_byp_a_q, f_byp_a_d;
   logic                  f_byp_b_q, f_byp_b_d;
   logic [DATA_WIDTH-1:0] f_data_a_q, f_data_a_d;
   logic [DATA_WIDTH-1:0] f_data_b_q, f_data_b_d;

   logic                  op_valid_q, op_valid_d;
   logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
   logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
   logic [AW-1:0]         op_rd_q, op_rd_d;
   logic [AW-1:0]         op_rs1_q, op_rs1_d;
   logic [AW-1:0]         op_rs2_q, op_rs2_d;

   logic f_adv, accept;
   logic hit_req_a, hit_req_b, hit_f_a, hit_f_b, hit_o_a, hit_o_b;

   function automatic logic [DATA_WIDTH-1:0] resolve(
      input logic [AW-1:0]         rs,
      input logic                  hit,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic                  byp,
      input logic [DATA_WIDTH-1:0] bdata,
      input logic [DATA_WIDTH-1:0] rdata
   );
      if (rs == '0)   return '0;
      else if (hit)   return wdata;
      else if (byp)   return bdata;
      else            return rdata;
   endfunction

   assign rs1_addr = req_rs1;
   assign rs2_addr = req_rs2;
   assign rd_addr  = wb_addr;
   assign rd_data  = wb_data;
   assign rd_wren  = wb_valid && (wb_addr != '0);

   assign f_adv     = f_valid_q && (!op_valid_q || op_ready);
   assign req_ready = !f_valid_q || f_adv;
   assign accept    = req_valid && req_ready;

   assign hit_req_a = rd_wren && (wb_addr == req_rs1);
   assign hit_req_b = rd_wren && (wb_addr == req_rs2);
   assign hit_f_a   = rd_wren && (wb_addr == f_rs1_q);
   assign hit_f_b   = rd_wren && (wb_addr == f_rs2_q);
   assign hit_o_a   = rd_wren && (wb_addr == op_rs1_q);
   assign hit_o_b   = rd_wren && (wb_addr == op_rs2_q);

   always_comb begin
      f_valid_d  = f_valid_q;
      f_fresh_d  = f_fresh_q;
      f_rs1_d    = f_rs1_q;
      f_rs2_d    = f_rs2_q;
      f_rd_d     = f_rd_q;
      f_byp_a_d  = f_byp_a_q;
      f_byp_b_d  = f_byp_b_q;
      f_data_a_d = f_data_a_q;
      f_data_b_d = f_data_b_q;
      if (accept) begin
         f_valid_d  = 1'b1;
         f_fresh_d  = 1'b1;
         f_rs1_d    = req_rs1;
         f_rs2_d    = req_rs2;
         f_rd_d     = req_rd;
         f_byp_a_d  = hit_req_a;
         f_byp_b_d  = hit_req_b;
         f_data_a_d = wb_data;
         f_data_b_d = wb_data;
      end else if (f_adv) begin
         f_valid_d = 1'b0;
         f_fresh_d = 1'b0;
         f_byp_a_d = 1'b0;
         f_byp_b_d = 1'b0;
      end else if (f_valid_q) begin
         // Stalled in F: the read data is only valid in the first F cycle, so
         // latch it then and keep following write-backs afterwards.
         f_fresh_d = 1'b0;
         if (hit_f_a) begin
            f_byp_a_d  = 1'b1;
            f_data_a_d = wb_data;
         end else if (f_fresh_q && !f_byp_a_q) begin
            f_byp_a_d  = 1'b1;
            f_data_a_d = rs1_data;
         end
         if (hit_f_b) begin
            f_byp_b_d  = 1'b1;
            f_data_b_d = wb_data;
         end else if (f_fresh_q && !f_byp_b_q) begin
            f_byp_b_d  = 1'b1;
            f_data_b_d = rs2_data;
         end
      end
   end

   always_comb begin
      op_valid_d = op_valid_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_rd_d    = op_rd_q;
      op_rs1_d   = op_rs1_q;
      op_rs2_d   = op_rs2_q;
      if (f_adv) begin
         op_valid_d = 1'b1;
         op_a_d     = resolve(f_rs1_q, hit_f_a, wb_data, f_byp_a_q, f_data_a_q, rs1_data);
         op_b_d     = resolve(f_rs2_q, hit_f_b, wb_data, f_byp_b_q, f_data_b_q, rs2_data);
         op_rd_d    = f_rd_q;
         op_rs1_d   = f_rs1_q;
         op_rs2_d   = f_rs2_q;
      end else if (op_valid_q && op_ready) begin
         op_valid_d = 1'b0;
      end else if (op_valid_q) begin
         if (hit_o_a) op_a_d = wb_data;
         if (hit_o_b) op_b_d = wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         f_valid_q  <= 1'b0;
         f_fresh_q  <= 1'b0;
         f_rs1_q    <= '0;
         f_rs2_q    <= '0;
         f_rd_q     <= '0;
         f_byp_a_q  <= 1'b0;
         f_byp_b_q  <= 1'b0;
         f_data_a_q <= '0;
         f_data_b_q <= '0;
         op_valid_q <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_rd_q    <= '0;
         op_rs1_q   <= '0;
         op_rs2_q   <= '0;
      end else begin
         f_valid_q  <= f_valid_d;
         f_fresh_q  <= f_fresh_d;
         f_rs1_q    <= f_rs1_d;
         f_rs2_q    <= f_rs2_d;
         f_rd_q     <= f_rd_d;
         f_byp_a_q  <= f_byp_a_d;
         f_byp_b_q  <= f_byp_b_d;
         f_data_a_q <= f_data_a_d;
         f_data_b_q <= f_data_b_d;
         op_valid_q <= op_valid_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_rd_q    <= op_rd_d;
         op_rs1_q   <= op_rs1_d;
         op_rs2_q   <= op_rs2_d;
      end
   end

   assign op_valid = op_valid_q;
   assign op_a     = op_a_q;
   assign op_b     = op_b_q;
   assign op_rd    = op_rd_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and write-back data width.
REQ-002 SHALL have parameter REG_NUM, default 32, register count; AW = clog2(REG_NUM) is the address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req_valid / req_ready, input / output, 1 each, the operand-request handshake.
REQ-006 SHALL have ports req_rs1, req_rs2, req_rd, input, AW each, the source and destination register numbers.
REQ-007 SHALL have ports wb_valid (input, 1), wb_addr (input, AW), wb_data (input, DATA_WIDTH), the write-back request, always accepted.
REQ-008 SHALL have ports rs1_addr and rs2_addr, output, AW each, register-file read addresses.
REQ-009 SHALL have ports rs1_data and rs2_data, input, DATA_WIDTH each, register-file read data, registered with one-cycle latency.
REQ-010 SHALL have ports rd_addr (output, AW), rd_data (output, DATA_WIDTH), rd_wren (output, 1), the register-file write port.
REQ-011 SHALL have ports op_valid / op_ready, output / input, 1 each, the operand-output handshake.
REQ-012 SHALL have ports op_a, op_b (output, DATA_WIDTH each) and op_rd (output, AW), the resolved operands and destination tag.

Function
REQ-013 SHALL drive rs1_addr = req_rs1 and rs2_addr = req_rs2 combinationally every cycle.
REQ-014 SHALL drive rd_addr = wb_addr, rd_data = wb_data and rd_wren = wb_valid && (wb_addr != 0), all combinationally.
REQ-015 SHALL contain two stages: F (read in flight: f_valid, f_rs1, f_rs2, f_rd, per-operand bypass flag and bypass data) and O (output: op_valid, op_a, op_b, op_rd).
REQ-016 SHALL accept a request on a cycle with req_valid && req_ready; req_ready = !f_valid || f_adv, where f_adv = f_valid && (!op_valid || op_ready).
REQ-017 SHALL, in the accept cycle, set the bypass flag for operand a if wb_valid && wb_addr == req_rs1 && req_rs1 != 0, and store wb_data as its bypass data; operand b uses req_rs2 in the same way.
REQ-018 SHALL, on f_adv, load op_a by priority: (1) 0 if f_rs1 == 0; (2) wb_data if wb_valid && wb_addr == f_rs1 in that cycle; (3) the bypass data if the bypass flag is set; (4) rs1_data. op_b is loaded the same way using f_rs2 and rs2_data.
REQ-019 SHALL, while op_valid && !op_ready, overwrite held op_a (or op_b) with wb_data on any wb_valid && wb_addr == the held source address, when that address is nonzero.
REQ-020 SHALL clear op_valid on op_ready when no f_adv occurs in the same cycle; f_valid clears on f_adv when no new accept occurs in the same cycle.
REQ-021 SHALL sustain one request per cycle with back-to-back op_ready, with a latency of 2 cycles from accept to op_valid.
REQ-022 SHALL hold op_a, op_b and op_rd stable while op_valid && !op_ready, except for the updates in REQ-019.
REQ-023 SHALL ignore a write-back to register 0 for both bypass and rd_wren.

Reset
REQ-024 SHALL, on assertion of rst low, clear f_valid, op_valid, all bypass flags, op_a, op_b and op_rd asynchronously; in-flight requests are dropped.
REQ-025 SHALL drive req_ready = 1 and op_valid = 0 on the first cycle after reset release.

Verification
REQ-026 SHALL cover: regfile x5 = 0x11; request rs1 = 5, rs2 = 0, op_ready = 1 -> two cycles later op_valid = 1, op_a = 0x11, op_b = 0.
REQ-027 SHALL cover: wb x7 = 0xAB in the same cycle a request with rs1 = 7 is accepted -> op_a = 0xAB, not the old x7 value.
REQ-028 SHALL cover: wb x3 = 0x55 in the F cycle of a request with rs2 = 3 -> op_b = 0x55.
REQ-029 SHALL cover: op_ready = 0 holding an output with rs1 = 9, then wb x9 = 0x99 -> held op_a becomes 0x99; no new request is accepted once F is occupied.
REQ-030 SHALL cover: wb_valid with wb_addr = 0, data 0xFF -> rd_wren = 0, and an operand from register 0 reads 0.
REQ-031 SHALL cover: rst pulsed low with both stages full -> op_valid = 0 immediately, and req_ready = 1 after release.
